// File: rtl/ypbpr_csync_out.sv
// Registered component-video output stage: sync-on-Y with serrated vertical sync,
// or registered RGB pass-through with separate composite sync when YPbPr is disabled.
module ypbpr_csync_out #(
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned BLACK_Y = 4,
    parameter int unsigned MID_C   = 32
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       en_ypbpr,
    input  logic [5:0] y_in,
    input  logic [5:0] pb_in,
    input  logic [5:0] pr_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       blank_in,
    output logic [5:0] y_out,
    output logic [5:0] pb_out,
    output logic [5:0] pr_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       csync_out
);

    localparam logic [5:0]       BlackY = 6'(BLACK_Y);
    localparam logic [5:0]       MidC   = 6'(MID_C);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] hlen_q, hlen_d;
    logic [CNT_W-1:0] hsw_q, hsw_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             hs_prev_q, hs_prev_d;
    logic             valid_q, valid_d;

    logic [5:0] y_out_q, y_out_d;
    logic [5:0] pb_out_q, pb_out_d;
    logic [5:0] pr_out_q, pr_out_d;
    logic       hs_out_q, hs_out_d;
    logic       vs_out_q, vs_out_d;
    logic       cs_out_q, cs_out_d;

    logic             rise, fall;
    logic [CNT_W-1:0] pos_inc, cur, half;
    logic             in_gap, cs;

    always_comb begin
        rise    = hs_in & ~hs_prev_q;
        fall    = ~hs_in & hs_prev_q;
        pos_inc = (pos_q == CntMax) ? CntMax : pos_q + CntOne;
        cur     = rise ? '0 : pos_inc;
        half    = hlen_q >> 1;

        // Serration gaps: one ending at mid-line, one ending at line end, each hsw wide.
        in_gap = (hsw_q < half) &&
                 (((cur >= half - hsw_q) && (cur < half)) || (cur >= hlen_q - hsw_q));

        if (!vs_in) begin
            cs = hs_in;
        end else if (!valid_q) begin
            cs = 1'b1;
        end else begin
            cs = ~in_gap;
        end
    end

    always_comb begin
        pos_d     = pos_q;
        hlen_d    = hlen_q;
        hsw_d     = hsw_q;
        wcnt_d    = wcnt_q;
        hs_prev_d = hs_prev_q;
        valid_d   = valid_q;
        y_out_d   = y_out_q;
        pb_out_d  = pb_out_q;
        pr_out_d  = pr_out_q;
        hs_out_d  = hs_out_q;
        vs_out_d  = vs_out_q;
        cs_out_d  = cs_out_q;

        if (ce_pix) begin
            pos_d     = cur;
            hs_prev_d = hs_in;

            if (rise) begin
                hlen_d  = pos_inc;
                valid_d = valid_q | (hlen_q != '0);
                wcnt_d  = CntOne;
            end else if (hs_in && (wcnt_q != CntMax)) begin
                wcnt_d = wcnt_q + CntOne;
            end

            if (fall) begin
                hsw_d = wcnt_q;
            end

            hs_out_d = hs_in;
            vs_out_d = vs_in;
            cs_out_d = cs;

            if (en_ypbpr && cs) begin
                y_out_d  = '0;
                pb_out_d = MidC;
                pr_out_d = MidC;
            end else if (en_ypbpr && blank_in) begin
                y_out_d  = BlackY;
                pb_out_d = MidC;
                pr_out_d = MidC;
            end else begin
                y_out_d  = y_in;
                pb_out_d = pb_in;
                pr_out_d = pr_in;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos_q     <= '0;
            hlen_q    <= '0;
            hsw_q     <= '0;
            wcnt_q    <= '0;
            hs_prev_q <= 1'b0;
            valid_q   <= 1'b0;
            y_out_q   <= '0;
            pb_out_q  <= MidC;
            pr_out_q  <= MidC;
            hs_out_q  <= 1'b0;
            vs_out_q  <= 1'b0;
            cs_out_q  <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            hlen_q    <= hlen_d;
            hsw_q     <= hsw_d;
            wcnt_q    <= wcnt_d;
            hs_prev_q <= hs_prev_d;
            valid_q   <= valid_d;
            y_out_q   <= y_out_d;
            pb_out_q  <= pb_out_d;
            pr_out_q  <= pr_out_d;
            hs_out_q  <= hs_out_d;
            vs_out_q  <= vs_out_d;
            cs_out_q  <= cs_out_d;
        end
    end

    assign y_out     = y_out_q;
    assign pb_out    = pb_out_q;
    assign pr_out    = pr_out_q;
    assign hs_out    = hs_out_q;
    assign vs_out    = vs_out_q;
    assign csync_out = cs_out_q;

endmodule

// File: tb/tb_ypbpr_csync_out.sv
// Bench for ypbpr_csync_out: directed line patterns plus randomized frames, all checked
// against a sample-by-sample behavioural model of the output stage.
module tb_ypbpr_csync_out;

    localparam int MaxPos = 4095;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce_pix = 1'b0;
    logic       en_ypbpr = 1'b0;
    logic [5:0] y_in = '0, pb_in = '0, pr_in = '0;
    logic       hs_in = 1'b0, vs_in = 1'b0, blank_in = 1'b0;
    logic [5:0] y_out, pb_out, pr_out;
    logic       hs_out, vs_out, csync_out;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: samples since last hs rise, measured line and pulse lengths, rise count.
    int m_pos, m_hlen, m_hsw, m_hicnt, m_rises;
    bit m_hsprev;
    logic [5:0] e_y = '0, e_pb = 6'd32, e_pr = 6'd32;
    logic       e_hs = 1'b0, e_vs = 1'b0, e_cs = 1'b0;

    ypbpr_csync_out #(
        .CNT_W  (12),
        .BLACK_Y(4),
        .MID_C  (32)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .en_ypbpr (en_ypbpr),
        .y_in     (y_in),
        .pb_in    (pb_in),
        .pr_in    (pr_in),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .blank_in (blank_in),
        .y_out    (y_out),
        .pb_out   (pb_out),
        .pr_out   (pr_out),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .csync_out(csync_out)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one clock of stimulus, advance the model, then compare all outputs.
    task automatic cycle(input bit ce, input bit rst, input bit en, input logic [5:0] y,
                         input logic [5:0] pb, input logic [5:0] pr, input bit hs,
                         input bit vs, input bit bl);
        bit rise, fall, cs, gap;
        int cur, half;
        ce_pix = ce; reset = rst; en_ypbpr = en;
        y_in = y; pb_in = pb; pr_in = pr; hs_in = hs; vs_in = vs; blank_in = bl;
        if (rst) begin
            m_pos = 0; m_hlen = 0; m_hsw = 0; m_hicnt = 0; m_rises = 0; m_hsprev = 0;
            e_y = 0; e_pb = 6'd32; e_pr = 6'd32; e_hs = 0; e_vs = 0; e_cs = 0;
        end else if (ce) begin
            rise = hs && !m_hsprev;
            fall = !hs && m_hsprev;
            cur  = rise ? 0 : ((m_pos >= MaxPos) ? MaxPos : m_pos + 1);
            half = m_hlen / 2;
            gap  = (m_hsw < half) &&
                   ((cur >= half - m_hsw && cur < half) || cur >= m_hlen - m_hsw);
            if (!vs) cs = hs;
            else if (m_rises < 2) cs = 1;
            else cs = !gap;
            e_hs = hs; e_vs = vs; e_cs = cs;
            if (en && cs) begin
                e_y = 0; e_pb = 32; e_pr = 32;
            end else if (en && bl) begin
                e_y = 4; e_pb = 32; e_pr = 32;
            end else begin
                e_y = y; e_pb = pb; e_pr = pr;
            end
            if (rise) begin
                m_hlen = (m_pos >= MaxPos) ? MaxPos : m_pos + 1;
                m_rises++;
                m_hicnt = 1;
            end else if (hs) begin
                m_hicnt++;
            end
            if (fall) m_hsw = m_hicnt;
            m_pos = cur;
            m_hsprev = hs;
        end
        @(posedge clk_sys);
        #1;
        check_eq("y_out", y_out, e_y);
        check_eq("pb_out", pb_out, e_pb);
        check_eq("pr_out", pr_out, e_pr);
        check_eq("hs_out", hs_out, e_hs);
        check_eq("vs_out", vs_out, e_vs);
        check_eq("csync_out", csync_out, e_cs);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1, 1, $urandom_range(0, 1), 6'($urandom), 6'($urandom), 6'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        check_eq("rst_y", y_out, 0);
        check_eq("rst_pb", pb_out, 32);
        check_eq("rst_pr", pr_out, 32);
        check_eq("rst_cs", csync_out, 0);
    endtask

    // One video line; yval < 0 means random luma. dir enables the fixed 16-pixel pattern checks.
    task automatic run_line(input int len, input int hw, input int blw, input bit vs,
                            input bit en, input int skip, input int yval, input bit dir,
                            input bit serr);
        logic [5:0] y, pb, pr;
        bit hs, bl, exp_cs;
        int exp_y;
        for (int p = 0; p < len; p++) begin
            hs = (p < hw);
            bl = (p < blw);
            y  = (yval < 0) ? 6'($urandom) : 6'(yval);
            pb = 6'($urandom);
            pr = 6'($urandom);
            for (int k = 0; k < skip; k++) cycle(0, 0, en, y, pb, pr, hs, vs, bl);
            cycle(1, 0, en, y, pb, pr, hs, vs, bl);
            if (dir) begin
                if (!vs) exp_cs = (p < 2);
                else if (serr) exp_cs = !(p == 6 || p == 7 || p == 14 || p == 15);
                else exp_cs = 1;
                if (!en) exp_y = yval;
                else if (exp_cs) exp_y = 0;
                else if (p < 4) exp_y = 4;
                else exp_y = yval;
                check_eq("dir_cs", csync_out, exp_cs);
                check_eq("dir_y", y_out, exp_y);
            end
        end
    endtask

    task automatic frame_16(input int skip);
        do_reset();
        for (int l = 0; l < 2; l++) run_line(16, 2, 4, 0, 1, skip, 40, 1, 0);
        for (int l = 0; l < 3; l++) run_line(16, 2, 4, 1, 1, skip, 40, 1, 1);
        run_line(16, 2, 4, 0, 1, skip, 40, 1, 0);
    endtask

    initial begin
        m_pos = 0; m_hlen = 0; m_hsw = 0; m_hicnt = 0; m_rises = 0; m_hsprev = 0;

        frame_16(0);

        // vs immediately after reset: no line timing yet, so no serration.
        do_reset();
        run_line(16, 2, 4, 1, 1, 0, 40, 1, 0);
        run_line(16, 2, 4, 0, 1, 0, 40, 1, 0);

        // Pass-through: no forcing of video, csync still follows hs.
        for (int l = 0; l < 2; l++) run_line(16, 2, 4, 0, 0, 0, 63, 1, 0);

        frame_16(2);

        // Randomized frames with varying timing, enables, gaps and mid-frame resets.
        do_reset();
        for (int l = 0; l < 80; l++) begin
            int len, hw, blw;
            len = $urandom_range(12, 40);
            hw  = $urandom_range(1, 6);
            blw = $urandom_range(hw, hw + 6);
            if ($urandom_range(0, 15) == 0) do_reset();
            run_line(len, hw, blw, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                     $urandom_range(0, 2), -1, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
